// File: rtl/program_loader.sv
// program_loader: receives a length-prefixed little-endian byte stream, writes its words
// into instruction memory and releases the CPU only after a complete, in-range load.
module program_loader #(
  parameter int ADDRESS_BITWIDTH = 12
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        in_valid,
  input  logic [7:0]                  in_data,
  output logic                        in_ready,
  output logic                        rom_wren,
  output logic [ADDRESS_BITWIDTH-1:0] rom_address,
  output logic [31:0]                 rom_write_data,
  output logic                        cpu_reset_n,
  output logic                        done,
  output logic                        error
);
  localparam int IW = ADDRESS_BITWIDTH - 2;
  localparam logic [31:0] MAX_WORDS = 32'(1) << IW;
  typedef enum logic [2:0] {IDLE, LEN, DATA, DONE, ERROR} state_t;
  state_t state, state_next;
  logic [1:0] byte_cnt;
  logic [23:0] partial;
  logic [IW:0] n_words;
  logic [IW-1:0] word_index;
  logic accept, last_byte, last_word;
  logic [31:0] word;
  assign in_ready = state == LEN || state == DATA;
  assign accept = in_valid && in_ready;
  assign last_byte = accept && byte_cnt == 2'd3;
  // The fourth byte completes the group directly from the input, no extra cycle.
  assign word = {in_data, partial};
  assign last_word = {1'b0, word_index} == n_words - (IW+1)'(1);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_next;
  always_comb begin
    state_next = state;
    case (state)
      IDLE: state_next = LEN;
      LEN: if (last_byte) state_next = word > MAX_WORDS ? ERROR : word == 32'd0 ? DONE : DATA;
      DATA: if (last_byte && last_word) state_next = DONE;
      default: state_next = state;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      byte_cnt <= '0;
      partial <= '0;
      n_words <= '0;
      word_index <= '0;
      rom_wren <= 1'b0;
      rom_address <= '0;
      rom_write_data <= '0;
      done <= 1'b0;
      cpu_reset_n <= 1'b0;
      error <= 1'b0;
    end else begin
      byte_cnt <= state_next != state ? 2'd0 : accept ? byte_cnt + 2'd1 : byte_cnt;
      if (accept) partial <= {in_data, partial[23:8]};
      rom_wren <= state == DATA && last_byte;
      if (state == LEN && last_byte) begin
        n_words <= word[IW:0];
        word_index <= '0;
      end
      if (state == DATA && last_byte) begin
        rom_address <= {word_index, 2'b00};
        rom_write_data <= word;
        word_index <= word_index + IW'(1);
      end
      done <= done | (state == DONE);
      cpu_reset_n <= cpu_reset_n | (state == DONE);
      error <= error | (state == ERROR);
    end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: randomized and directed loads checked every cycle against a
// stream-level reference model of the loader.
module tb_program_loader;
  logic clk = 0, reset_n = 0, in_valid = 0;
  logic [7:0] in_data = 0;
  logic in_ready, rom_wren, cpu_reset_n, done, error;
  logic [11:0] rom_address;
  logic [31:0] rom_write_data;
  always #5 clk = ~clk;
  program_loader #(.ADDRESS_BITWIDTH(12)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .rom_wren(rom_wren), .rom_address(rom_address),
    .rom_write_data(rom_write_data), .cpu_reset_n(cpu_reset_n), .done(done), .error(error)
  );
  int tests = 0, fails = 0;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // Reference model: tracks bytes taken, decodes length/words from a byte queue.
  bit m_started, m_fin, m_err, m_done_o, m_err_o, m_wren, m_acc;
  logic [11:0] m_addr;
  logic [31:0] m_data, m_n, m_w;
  int m_cnt, m_words;
  logic [7:0] m_q[$];
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_started = 0; m_fin = 0; m_err = 0; m_done_o = 0; m_err_o = 0; m_wren = 0;
      m_addr = 0; m_data = 0; m_n = 0; m_cnt = 0; m_words = 0; m_q.delete();
    end else begin
      m_acc = in_valid && m_started && !m_fin && !m_err;
      m_wren = 0;
      m_done_o = m_done_o | m_fin;
      m_err_o = m_err_o | m_err;
      m_started = 1;
      if (m_acc) begin
        m_q.push_back(in_data);
        m_cnt++;
        if (m_q.size() == 4) begin
          m_w = {m_q[3], m_q[2], m_q[1], m_q[0]};
          m_q.delete();
          if (m_cnt == 4) begin
            m_n = m_w;
            if (m_w > 32'd1024) m_err = 1;
            else if (m_w == 0) m_fin = 1;
          end else begin
            m_wren = 1;
            m_addr = 12'(m_words * 4);
            m_data = m_w;
            m_words++;
            if (m_words == int'(m_n)) m_fin = 1;
          end
        end
      end
    end
  end
  logic [11:0] wa[$];
  logic [31:0] wd[$];
  int cyc = 0, last_wr_cyc = 0, done_cyc = -1;
  always @(negedge clk) begin
    check("in_ready", in_ready, m_started && !m_fin && !m_err);
    check("rom_wren", rom_wren, m_wren);
    check("rom_address", 32'(rom_address), 32'(m_addr));
    check("rom_write_data", rom_write_data, m_data);
    check("done", done, m_done_o);
    check("cpu_reset_n", cpu_reset_n, m_done_o);
    check("error", error, m_err_o);
    if (rom_wren) begin
      wa.push_back(rom_address);
      wd.push_back(rom_write_data);
      last_wr_cyc = cyc;
    end
    if (done && done_cyc < 0) done_cyc = cyc;
    cyc++;
  end
  logic [7:0] img[$];
  task automatic tick; @(negedge clk); #1; endtask
  task automatic clr_log; wa.delete(); wd.delete(); done_cyc = -1; endtask
  task automatic do_reset;
    in_valid = 0; reset_n = 0;
    repeat (2) tick;
    reset_n = 1;
  endtask
  task automatic add_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) img.push_back(w[8*i +: 8]);
  endtask
  task automatic send(input logic [7:0] b, input int gaps);
    int t = 0;
    in_valid = 1; in_data = b;
    while (!in_ready && t < 20) begin tick; t++; end
    if (t == 20) begin
      tests++; fails++;
      $display("FAIL send_timeout: in_ready stayed 0, required 1");
    end
    tick;
    in_valid = 0; in_data = 8'($urandom);
    repeat (gaps) tick;
  endtask
  task automatic send_img(input int nbytes, input int gapmax);
    for (int i = 0; i < nbytes; i++) send(img[i], $urandom_range(0, gapmax));
  endtask
  task automatic offer(input int n);
    in_valid = 1;
    repeat (n) begin in_data = 8'($urandom); tick; end
    in_valid = 0;
  endtask
  task automatic two_word;
    img.delete(); add_word(2); add_word(32'h13); add_word(32'h00100093);
  endtask
  task automatic pin_two_word(input string tag);
    check({tag, "_count"}, wa.size(), 2);
    check({tag, "_w0_addr"}, 32'(wa[0]), 0);
    check({tag, "_w0_data"}, wd[0], 32'h13);
    check({tag, "_w1_addr"}, 32'(wa[1]), 4);
    check({tag, "_w1_data"}, wd[1], 32'h00100093);
    check({tag, "_done_delay"}, done_cyc - last_wr_cyc, 1);
    check({tag, "_cpu_rel"}, cpu_reset_n, 1);
  endtask
  initial begin
    int n, k, kind;
    do_reset;
    reset_n = 0; tick;
    check("rst_in_ready", in_ready, 0);
    check("rst_outs", {rom_wren, cpu_reset_n, done, error}, 0);
    check("rst_addr_data", rom_address | rom_write_data, 0);
    reset_n = 1;
    // back-to-back two-word image
    clr_log; two_word; send_img(12, 0); repeat (3) tick;
    pin_two_word("b2b");
    check("model_done", m_done_o, 1);
    // empty image
    do_reset; clr_log; img.delete(); add_word(0); send_img(4, 0); repeat (3) tick;
    check("empty_count", wa.size(), 0);
    check("empty_done", done, 1);
    check("empty_ready", in_ready, 0);
    // gaps between every byte, then bytes offered after DONE
    do_reset; clr_log; two_word; send_img(12, 1); repeat (2) tick; offer(4); tick;
    pin_two_word("gap");
    check("gap_ready", in_ready, 0);
    // overflow by one word
    do_reset; clr_log; img.delete(); add_word(32'h401); send_img(4, 0); offer(3); repeat (2) tick;
    check("ovf_error", error, 1);
    check("ovf_cpu", cpu_reset_n, 0);
    check("ovf_ready", in_ready, 0);
    check("ovf_count", wa.size(), 0);
    // exactly full capacity
    do_reset; clr_log; img.delete(); add_word(32'h400);
    for (int i = 0; i < 1024; i++) add_word($urandom);
    send_img(img.size(), 0); repeat (3) tick;
    check("full_count", wa.size(), 1024);
    check("full_last_addr", 32'(wa[1023]), 32'hFFC);
    check("full_done", done, 1);
    // reset in the middle of the first data word
    do_reset; clr_log; two_word; send_img(6, 0); do_reset; send_img(12, 0); repeat (3) tick;
    pin_two_word("midrst");
    // randomized loads
    for (int it = 0; it < 40; it++) begin
      do_reset; clr_log; img.delete();
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        add_word($urandom_range(0, 1) ? 32'd1025 + $urandom_range(0, 50) : $urandom | 32'h01000000);
        send_img(4, $urandom_range(0, 2)); offer(2); tick;
        check("rnd_ovf_error", error, 1);
        check("rnd_ovf_count", wa.size(), 0);
      end else begin
        n = kind == 1 ? 0 : $urandom_range(1, 12);
        add_word(n);
        for (int i = 0; i < n; i++) add_word($urandom);
        if (kind == 2) begin
          k = $urandom_range(1, img.size() - 1);
          send_img(k, $urandom_range(0, 2));
          do_reset; clr_log;
          check("rnd_rst_cpu", cpu_reset_n, 0);
        end else begin
          send_img(img.size(), $urandom_range(0, 2)); repeat (2) tick; offer(2); tick;
          check("rnd_count", wa.size(), n);
          check("rnd_done", done, 1);
          check("rnd_ready", in_ready, 0);
        end
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
